// File: rtl/itcm_rsp_pkg.sv
// itcm_rsp_pkg: shared bus widths, ITCM defaults and the response payload type
// used by the instruction-fetch responder and its response FIFO.
package itcm_rsp_pkg;

  localparam int unsigned MYRISCV_ADDRBUS    = 32;
  localparam int unsigned MYRISCV_DATABUS    = 32;
  localparam logic [31:0] MYRISCV_ITCM_BASE  = 32'h8000_0000;
  localparam int unsigned MYRISCV_ITCM_DEPTH = 16384;

  // One fetch response as carried on ifu_rsp_* and stored in the FIFO.
  typedef struct packed {
    logic                       err;
    logic [MYRISCV_DATABUS-1:0] data;
  } itcm_rsp_t;

  localparam itcm_rsp_t RSP_NONE = '{err: 1'b0, data: '0};

  // Byte offset of a fetch from the ITCM base; wraps for addresses below base.
  function automatic logic [MYRISCV_ADDRBUS-1:0] itcm_offset(
    input logic [MYRISCV_ADDRBUS-1:0] addr,
    input logic [MYRISCV_ADDRBUS-1:0] base
  );
    return addr - base;
  endfunction

endpackage

// File: rtl/itcm_rsp_fifo.sv
// itcm_rsp_fifo: 2-entry in-order response FIFO with occupancy count.
// Ports:
//   clk          - clock
//   rst_ni       - synchronous active-low reset (pointers and count)
//   push_i       - write push_data_i at the tail
//   push_data_i  - response to store
//   pop_i        - drop the head entry
//   head_o       - current head entry (valid when cnt_o != 0)
//   cnt_o        - number of stored entries, 0..2
module itcm_rsp_fifo
  import itcm_rsp_pkg::*;
(
  input  logic      clk,
  input  logic      rst_ni,
  input  logic      push_i,
  input  itcm_rsp_t push_data_i,
  input  logic      pop_i,
  output itcm_rsp_t head_o,
  output logic [1:0] cnt_o
);

  itcm_rsp_t  mem_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       do_push, do_pop;

  // Guard against push-when-full / pop-when-empty.
  assign do_push = push_i && (cnt_q != 2'd2);
  assign do_pop  = pop_i  && (cnt_q != 2'd0);

  // Next-state for pointers and count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = ~wr_ptr_q;
    if (do_pop)  rd_ptr_d = ~rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; entries are only read when counted.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o = mem_q[rd_ptr_q];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/itcm_rsp.sv
// itcm_rsp: instruction-fetch responder at the memory end of the IFU fetch bus.
// Decodes fetch addresses, reads a 1-cycle-latency SRAM for good fetches and
// returns in-order {data, err} responses with full backpressure.
// Ports:
//   clk, rst         - clock; synchronous active-low reset
//   ifu_req_vld/rdy  - fetch request handshake
//   ifu_req_addr     - byte address of the fetch
//   ifu_rsp_vld/rdy  - response handshake
//   ifu_rsp_data/err - instruction word (0 on error) and bus error flag
//   sram_cs/addr     - SRAM read enable and word index
//   sram_rdata       - SRAM read data, valid the cycle after sram_cs
module itcm_rsp
  import itcm_rsp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = MYRISCV_ITCM_BASE,
  parameter int unsigned DEPTH_WORDS = MYRISCV_ITCM_DEPTH,
  parameter int unsigned IDX_W       = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ifu_req_vld,
  output logic                       ifu_req_rdy,
  input  logic [MYRISCV_ADDRBUS-1:0] ifu_req_addr,
  output logic                       ifu_rsp_vld,
  input  logic                       ifu_rsp_rdy,
  output logic [MYRISCV_DATABUS-1:0] ifu_rsp_data,
  output logic                       ifu_rsp_err,
  output logic                       sram_cs,
  output logic [IDX_W-1:0]           sram_addr,
  input  logic [31:0]                sram_rdata
);

  logic [MYRISCV_ADDRBUS-1:0] offset;
  logic       mis, oor, bad, acc, credit_ok;
  logic       if_vld_q, if_err_q;
  logic [1:0] fifo_cnt;
  logic       fifo_empty, fifo_push, fifo_pop;
  itcm_rsp_t  fifo_head, src, rsp_sel;

  // Address decode: misaligned or outside the window never touches the SRAM.
  assign offset = itcm_offset(ifu_req_addr, BASE_ADDR);
  assign mis    = |ifu_req_addr[1:0];
  assign oor    = {1'b0, offset} >= (33'(DEPTH_WORDS) << 2);
  assign bad    = mis | oor;

  // Credit from registered state: an inflight word always has a FIFO slot.
  assign credit_ok   = (3'(fifo_cnt) + 3'(if_vld_q)) < 3'd2;
  assign ifu_req_rdy = rst & credit_ok;
  assign acc         = ifu_req_vld & ifu_req_rdy;

  assign sram_cs   = acc & ~bad;
  assign sram_addr = offset[IDX_W+1:2];

  // Inflight stage tracks the fetch whose SRAM read is in progress.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if_vld_q <= 1'b0;
      if_err_q <= 1'b0;
    end else begin
      if_vld_q <= acc;
      if_err_q <= bad;
    end
  end

  // Response source for the inflight fetch.
  always_comb begin
    src      = RSP_NONE;
    src.err  = if_err_q;
    src.data = if_err_q ? '0 : sram_rdata;
  end

  // Bypass when the FIFO is empty and the IFU takes the word; else enqueue.
  assign fifo_empty = (fifo_cnt == 2'd0);
  assign fifo_push  = if_vld_q & ~(fifo_empty & ifu_rsp_rdy);
  assign fifo_pop   = ~fifo_empty & ifu_rsp_rdy;

  itcm_rsp_fifo u_fifo (
    .clk         (clk),
    .rst_ni      (rst),
    .push_i      (fifo_push),
    .push_data_i (src),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .cnt_o       (fifo_cnt)
  );

  assign rsp_sel      = fifo_empty ? src : fifo_head;
  assign ifu_rsp_vld  = rst & (~fifo_empty | if_vld_q);
  assign ifu_rsp_data = ifu_rsp_vld ? rsp_sel.data : '0;
  assign ifu_rsp_err  = ifu_rsp_vld & rsp_sel.err;

endmodule

// File: tb/tb_itcm_rsp.sv
// Self-checking bench for itcm_rsp: directed scenarios plus randomized traffic
// checked every cycle against a queue-based model of outstanding fetches.
module tb_itcm_rsp;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_vld;
  logic        ifu_req_rdy;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_vld;
  logic        ifu_rsp_rdy;
  logic [31:0] ifu_rsp_data;
  logic        ifu_rsp_err;
  logic        sram_cs;
  logic [13:0] sram_addr;
  logic [31:0] sram_rdata = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  itcm_rsp dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_req_vld  (ifu_req_vld),
    .ifu_req_rdy  (ifu_req_rdy),
    .ifu_req_addr (ifu_req_addr),
    .ifu_rsp_vld  (ifu_rsp_vld),
    .ifu_rsp_rdy  (ifu_rsp_rdy),
    .ifu_rsp_data (ifu_rsp_data),
    .ifu_rsp_err  (ifu_rsp_err),
    .sram_cs      (sram_cs),
    .sram_addr    (sram_addr),
    .sram_rdata   (sram_rdata)
  );

  // SRAM contents: a fixed scramble of the index, nonzero at index 0.
  function automatic logic [31:0] word(input logic [13:0] i);
    return 32'hC0DE_0000 ^ (32'(i) * 32'h9E37_79B9);
  endfunction

  function automatic logic addr_bad(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a[1:0] != 2'b00) || (off >= 32'h0001_0000);
  endfunction

  function automatic logic [13:0] addr_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off[15:2];
  endfunction

  function automatic logic [32:0] exp_rsp(input logic [31:0] a);
    if (addr_bad(a)) return {1'b1, 32'h0};
    return {1'b0, word(addr_idx(a))};
  endfunction

  // 1-cycle-latency SRAM model.
  always @(posedge clk) begin
    if (sram_cs) sram_rdata <= word(sram_addr);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: queue of responses owed to the IFU, in acceptance order.
  logic [32:0] owed[$];

  always @(negedge clk) begin
    logic exp_rdy, exp_cs;
    if (!rst) begin
      chk("rst_req_rdy", 32'(ifu_req_rdy), 32'd0);
      chk("rst_rsp_vld", 32'(ifu_rsp_vld), 32'd0);
      chk("rst_sram_cs", 32'(sram_cs), 32'd0);
      chk("rst_rsp_data", ifu_rsp_data, 32'd0);
      chk("rst_rsp_err", 32'(ifu_rsp_err), 32'd0);
      owed.delete();
    end else begin
      exp_rdy = owed.size() < 2;
      exp_cs  = ifu_req_vld && exp_rdy && !addr_bad(ifu_req_addr);
      chk("req_rdy", 32'(ifu_req_rdy), 32'(exp_rdy));
      chk("rsp_vld", 32'(ifu_rsp_vld), 32'(owed.size() != 0));
      if (owed.size() != 0) begin
        chk("rsp_data", ifu_rsp_data, owed[0][31:0]);
        chk("rsp_err", 32'(ifu_rsp_err), 32'(owed[0][32]));
      end
      chk("sram_cs", 32'(sram_cs), 32'(exp_cs));
      if (exp_cs) chk("sram_addr", 32'(sram_addr), 32'(addr_idx(ifu_req_addr)));
      if (owed.size() != 0 && ifu_rsp_rdy) void'(owed.pop_front());
      if (ifu_req_vld && exp_rdy) owed.push_back(exp_rsp(ifu_req_addr));
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b0;
    ifu_req_vld  = 1'b0;
    ifu_req_addr = 32'h0;
    ifu_rsp_rdy  = 1'b1;
    repeat (3) @(negedge clk);
    chk("lit_reset_vld", 32'(ifu_rsp_vld), 32'd0);

    // Reset then stream four back-to-back fetches.
    nxt();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ifu_req_vld  = 1'b1;
      ifu_req_addr = BASE + 32'(4 * i);
      @(negedge clk);
      chk("lit_stream_rdy", 32'(ifu_req_rdy), 32'd1);
      if (i > 0) chk("lit_stream_data", ifu_rsp_data, word(14'(i - 1)));
      nxt();
    end
    ifu_req_vld = 1'b0;
    @(negedge clk);
    chk("lit_stream_last", ifu_rsp_data, word(14'd3));

    // Misaligned fetch.
    nxt();
    ifu_req_vld  = 1'b1;
    ifu_req_addr = 32'h8000_0002;
    @(negedge clk);
    chk("lit_mis_cs", 32'(sram_cs), 32'd0);
    nxt();
    ifu_req_vld = 1'b0;
    @(negedge clk);
    chk("lit_mis_vld", 32'(ifu_rsp_vld), 32'd1);
    chk("lit_mis_err", 32'(ifu_rsp_err), 32'd1);
    chk("lit_mis_data", ifu_rsp_data, 32'd0);

    // Range edges.
    nxt();
    ifu_req_vld  = 1'b1;
    ifu_req_addr = 32'h8000_FFFC;
    @(negedge clk);
    chk("lit_top_cs", 32'(sram_cs), 32'd1);
    chk("lit_top_idx", 32'(sram_addr), 32'h3FFF);
    nxt();
    ifu_req_addr = 32'h8001_0000;
    @(negedge clk);
    chk("lit_top_err", 32'(ifu_rsp_err), 32'd0);
    chk("lit_top_data", ifu_rsp_data, word(14'h3FFF));
    chk("lit_above_cs", 32'(sram_cs), 32'd0);
    nxt();
    ifu_req_addr = 32'h7FFF_FFFC;
    @(negedge clk);
    chk("lit_above_err", 32'(ifu_rsp_err), 32'd1);
    chk("lit_below_cs", 32'(sram_cs), 32'd0);
    nxt();
    ifu_req_vld = 1'b0;
    @(negedge clk);
    chk("lit_below_err", 32'(ifu_rsp_err), 32'd1);

    // Backpressure: three requests with rsp_rdy low, only two accepted.
    nxt();
    ifu_rsp_rdy  = 1'b0;
    ifu_req_vld  = 1'b1;
    ifu_req_addr = BASE + 32'h20;
    @(negedge clk);
    chk("lit_bp_rdy0", 32'(ifu_req_rdy), 32'd1);
    nxt();
    ifu_req_addr = BASE + 32'h24;
    @(negedge clk);
    chk("lit_bp_rdy1", 32'(ifu_req_rdy), 32'd1);
    nxt();
    ifu_req_addr = BASE + 32'h28;
    @(negedge clk);
    chk("lit_bp_rdy2", 32'(ifu_req_rdy), 32'd0);
    chk("lit_bp_hold0", ifu_rsp_data, word(14'd8));
    nxt();
    @(negedge clk);
    chk("lit_bp_rdy3", 32'(ifu_req_rdy), 32'd0);
    chk("lit_bp_hold1", ifu_rsp_data, word(14'd8));
    nxt();
    ifu_rsp_rdy = 1'b1;
    @(negedge clk);
    chk("lit_bp_out8", ifu_rsp_data, word(14'd8));
    chk("lit_bp_rdy4", 32'(ifu_req_rdy), 32'd0);
    nxt();
    @(negedge clk);
    chk("lit_bp_out9", ifu_rsp_data, word(14'd9));
    chk("lit_bp_rdy5", 32'(ifu_req_rdy), 32'd1);
    nxt();
    ifu_req_vld = 1'b0;
    @(negedge clk);
    chk("lit_bp_out10", ifu_rsp_data, word(14'd10));
    nxt();
    @(negedge clk);
    chk("lit_bp_idle", 32'(ifu_rsp_vld), 32'd0);

    // Reset mid-stream with the FIFO full.
    nxt();
    ifu_rsp_rdy  = 1'b0;
    ifu_req_vld  = 1'b1;
    ifu_req_addr = BASE;
    nxt();
    ifu_req_addr = BASE + 32'h4;
    nxt();
    ifu_req_vld = 1'b0;
    nxt();
    @(negedge clk);
    chk("lit_full_vld", 32'(ifu_rsp_vld), 32'd1);
    chk("lit_full_rdy", 32'(ifu_req_rdy), 32'd0);
    nxt();
    rst = 1'b0;
    nxt();
    @(negedge clk);
    chk("lit_mrst_vld", 32'(ifu_rsp_vld), 32'd0);
    chk("lit_mrst_rdy", 32'(ifu_req_rdy), 32'd0);
    nxt();
    rst          = 1'b1;
    ifu_rsp_rdy  = 1'b1;
    ifu_req_vld  = 1'b1;
    ifu_req_addr = BASE + 32'h10;
    @(negedge clk);
    chk("lit_post_vld", 32'(ifu_rsp_vld), 32'd0);
    nxt();
    ifu_req_vld = 1'b0;
    @(negedge clk);
    chk("lit_post_data", ifu_rsp_data, word(14'd4));
    nxt();
    @(negedge clk);
    chk("lit_post_idle", 32'(ifu_rsp_vld), 32'd0);

    // Randomized traffic with random backpressure and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      nxt();
      rst         = ($urandom_range(0, 249) != 0);
      ifu_req_vld = ($urandom_range(0, 3) != 0);
      ifu_rsp_rdy = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0, 1, 2: ifu_req_addr = BASE + {16'h0, 14'($urandom_range(0, 16383)), 2'b00};
        3:       ifu_req_addr = BASE + {16'h0, 14'($urandom_range(0, 16383)), 2'($urandom_range(1, 3))};
        4:       ifu_req_addr = BASE + 32'h0001_0000 + 32'($urandom_range(0, 4095)) * 4;
        default: ifu_req_addr = BASE - 32'($urandom_range(1, 8)) * 4;
      endcase
    end
    nxt();
    ifu_req_vld = 1'b0;
    ifu_rsp_rdy = 1'b1;
    repeat (4) nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
